// File: rtl/qr_pkg.sv
// Shared types and constants for the ChaCha quarter-round engine.
// Holds the 32-bit word type, the engine state encoding, the rotation
// amounts and small rotate helpers used by the step datapath.
package qr_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned ROT16 = 16;
  localparam int unsigned ROT12 = 12;
  localparam int unsigned ROT8  = 8;
  localparam int unsigned ROT7  = 7;

  // Rotate right; amounts are always compile-time constants in [1,31]
  function automatic word_t rotr(input word_t x, input int unsigned r);
    return (x >> r) | (x << (32 - r));
  endfunction

  // Rotate left; amounts are always compile-time constants in [1,31]
  function automatic word_t rotl(input word_t x, input int unsigned r);
    return (x << r) | (x >> (32 - r));
  endfunction

endpackage

// File: rtl/qr_inv_step.sv
// One half-step of the ChaCha quarter round, purely combinational.
// The default build only provides the inverse half-steps that unwind a
// forward quarter round. When QR_FWD_EN is defined an extra fwd_i input
// selects the forward half-steps instead, sharing the same step index.
module qr_inv_step
  import qr_pkg::*;
(
  input  word_t      a_i,
  input  word_t      b_i,
  input  word_t      c_i,
  input  word_t      d_i,
  input  logic [1:0] s_i,
`ifdef QR_FWD_EN
  input  logic       fwd_i,
`endif
  output word_t      a_o,
  output word_t      b_o,
  output word_t      c_o,
  output word_t      d_o
);

  logic fwd_sel;

`ifdef QR_FWD_EN
  assign fwd_sel = fwd_i;
`else
  assign fwd_sel = 1'b0;
`endif

  // Every step reads only the current words, so the "new" B or D that the
  // following subtraction/XOR needs is simply the value in the register.
  always_comb begin
    word_t sum;
    a_o = a_i;
    b_o = b_i;
    c_o = c_i;
    d_o = d_i;
    sum = '0;
    if (fwd_sel) begin
      case (s_i)
        2'd0: begin
          sum = a_i + b_i;
          a_o = sum;
          d_o = rotl(d_i ^ sum, ROT16);
        end
        2'd1: begin
          sum = c_i + d_i;
          c_o = sum;
          b_o = rotl(b_i ^ sum, ROT12);
        end
        2'd2: begin
          sum = a_i + b_i;
          a_o = sum;
          d_o = rotl(d_i ^ sum, ROT8);
        end
        default: begin
          sum = c_i + d_i;
          c_o = sum;
          b_o = rotl(b_i ^ sum, ROT7);
        end
      endcase
    end else begin
      case (s_i)
        2'd0: begin
          b_o = rotr(b_i, ROT7) ^ c_i;
          c_o = c_i - d_i;
        end
        2'd1: begin
          d_o = rotr(d_i, ROT8) ^ a_i;
          a_o = a_i - b_i;
        end
        2'd2: begin
          b_o = rotr(b_i, ROT12) ^ c_i;
          c_o = c_i - d_i;
        end
        default: begin
          d_o = rotr(d_i, ROT16) ^ a_i;
          a_o = a_i - b_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/qr_inv_iter.sv
// Iterative ChaCha inverse quarter-round engine.
// Accepts four words, applies 4*ITER inverse half-steps (one per clock) on
// an internal working register, then presents the recovered words until the
// consumer takes them. Optional macro QR_FWD_EN adds a fwd input that,
// captured at acceptance, runs the forward quarter round instead.
module qr_inv_iter
  import qr_pkg::*;
#(
  parameter int unsigned ITER = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] c_in,
  input  logic [31:0] d_in,
`ifdef QR_FWD_EN
  input  logic        fwd,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [31:0] c_out,
  output logic [31:0] d_out
);

  localparam int unsigned STEPS = 4 * ITER;
  localparam int unsigned CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  word_t            a_q, b_q, c_q, d_q;
  word_t            a_d, b_d, c_d, d_d;
  logic             out_valid_q;
  logic             in_ready_q;
`ifdef QR_FWD_EN
  logic             fwd_q;
`endif

  qr_inv_step u_step (
    .a_i   (a_q),
    .b_i   (b_q),
    .c_i   (c_q),
    .d_i   (d_q),
    .s_i   (cnt_q[1:0]),
`ifdef QR_FWD_EN
    .fwd_i (fwd_q),
`endif
    .a_o   (a_d),
    .b_o   (b_d),
    .c_o   (c_d),
    .d_o   (d_d)
  );

  // Control FSM plus working register: load on accept, step until the last
  // half-step, then hold the result until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef QR_FWD_EN
      fwd_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a_in;
            b_q        <= b_in;
            c_q        <= c_in;
            d_q        <= d_in;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= STEP;
`ifdef QR_FWD_EN
            fwd_q      <= fwd;
`endif
          end
        end
        STEP: begin
          a_q   <= a_d;
          b_q   <= b_d;
          c_q   <= c_d;
          d_q   <= d_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign c_out     = c_q;
  assign d_out     = d_q;

endmodule

// File: doc/qr_inv_iter.md
Name: qr_inv_iter

Overview:
- Iterative ChaCha inverse quarter-round engine: takes (a,b,c,d) words produced by the forward quarter round and recovers the original inputs.
- Executes one inverse half-step per clock on an internal 4x32-bit working register.
- Valid/ready handshakes on both sides.
- Sits beside the combinational forward quarter-round block; used for round-trip self-test and decrypt-side state unwinding.

Parameters:
ITER, 1, number of consecutive inverse quarter rounds applied to the same words (>=1); total steps = 4*ITER

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input words valid
in_ready  output  1  engine can accept input
a_in  input  32  word a
b_in  input  32  word b
c_in  input  32  word c
d_in  input  32  word d
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
a_out  output  32  recovered a (registered)
b_out  output  32  recovered b (registered)
c_out  output  32  recovered c (registered)
d_out  output  32  recovered d (registered)

Behaviour:
- One clock `clk`, reset `rst_n` asynchronous active-low (fixed). On assertion, at any time including mid-operation:
  - state=IDLE, step counter=0
  - working regs A,B,C,D=0 (so a_out..d_out=0)
  - out_valid=0, in_ready=1 after release
- States IDLE, STEP, DONE.
  - in_ready=1 only in IDLE; out_valid=1 only in DONE.
  - a_out..d_out always equal working regs A..D.
- IDLE: on in_valid&in_ready edge, load A..D from a_in..d_in, k=0, go to STEP. Inputs need not stay stable afterwards.
- STEP: each edge applies step s = k mod 4, then k++. All arithmetic is mod 2^32; rotr = rotate right.
  - s=0: B = rotr(B,7) ^ C;  C = C - D
  - s=1: D = rotr(D,8) ^ A;  A = A - B_new
  - s=2: B = rotr(B,12) ^ C; C = C - D
  - s=3: D = rotr(D,16) ^ A; A = A - B_new
  - Within a step: B_new/D_new are computed from the old values; C and A use the old D and the new B respectively, exactly as listed.
  - After the step with k=4*ITER-1, go to DONE.
- Latency: out_valid rises exactly 4*ITER clocks after the accepting edge.
- DONE: hold A..D and out_valid until out_valid&out_ready; that edge returns to IDLE and clears out_valid. Results are not cleared.
- in_valid in STEP/DONE is ignored (not accepted). out_ready outside DONE is ignored.
- Minimum spacing between acceptances: 4*ITER+2 clocks when out_ready is held high.
- No X propagation: every register has a reset value.

Optional Feature:
- Macro QR_FWD_EN.
- Defined:
  - Adds input port `fwd` (1 bit), sampled at acceptance and held in a mode register.
  - fwd=1 runs the forward quarter round. Per step s=0..3 with rotations 16,12,8,7:
    - even s: A = A + B; D = rotl(D ^ A_new, r)
    - odd s: C = C + D; B = rotl(B ^ C_new, r)
  - Forward uses the same counter, latency and handshake.
  - fwd=0 gives the inverse behaviour above.
- Undefined: `fwd` port and mode register are absent; the engine is inverse-only.

Decomposition:
- Package qr_pkg holds:
  - word typedef (32-bit)
  - state enum (IDLE/STEP/DONE)
  - rotation constants ROT16=16, ROT12=12, ROT8=8, ROT7=7
- Sub-module qr_inv_step: combinational, takes (A,B,C,D,s[1:0]) and returns the next (A,B,C,D). It includes the forward path under QR_FWD_EN.
- Counter width: $clog2(4*ITER) bits.

Test Plan:
- ITER=1, input a=ea2a92f4 b=cb1cf8ce c=4581472e d=5881c4bb (RFC 8439 2.1.1 outputs) -> out_valid 4 clocks after accept with a=11111111 b=01020304 c=9b8d6f43 d=01234567.
- Backpressure: out_ready=0 for 10 clocks after DONE -> outputs stable, in_ready=0, a second in_valid pulse not accepted; out_ready=1 -> IDLE next edge.
- Reset mid-operation: rst_n low 2 clocks after accept -> immediately out_valid=0, outputs 0, in_ready=1 after release; the next transaction is correct.
- ITER=2 round trip: feed a forward-forward result of the RFC inputs (computed by a reference model) -> RFC inputs returned after 8 clocks.
- Wrap-around: a=b=c=d=00000000 and a=b=c=d=ffffffff -> match the reference-model inverse (subtraction borrow across bit 31).
- QR_FWD_EN, fwd=1 with RFC inputs -> ea2a92f4 cb1cf8ce 4581472e 5881c4bb after 4 clocks; fwd=0 on the same build still passes scenario 1.
